// File: rtl/scene_int_seq.sv
// scene_int_seq: issue sequencer and result collector around the
// scene-intersection pipeline. Rays are issued over ISSUE_CYC cycles with
// one-hot axis strobes; ray IDs follow the fixed pipeline latency in a tag
// shift register, and results land in a show-ahead FIFO. Credits (rays in
// flight + FIFO entries) gate admission so the non-stallable pipeline can
// never overrun the FIFO.
module scene_int_seq #(
   parameter int unsigned ISSUE_CYC = 4,
   parameter int unsigned RES_LAT   = 40,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned ID_W      = 8,
   parameter int unsigned RAY_W     = 192
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [RAY_W-1:0] in_ray,
   input  logic [ID_W-1:0]  in_id,
   input  logic             in_shadow,
   output logic [RAY_W-1:0] pl_ray,
   output logic             pl_v0,
   output logic             pl_v1,
   output logic             pl_v2,
   output logic             pl_shadow,
   input  logic [31:0]      pl_tmin,
   input  logic [31:0]      pl_tmax,
   input  logic             pl_miss,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ID_W-1:0]  out_id,
   output logic [31:0]      out_tmin,
   output logic [31:0]      out_tmax,
   output logic             out_miss,
   output logic             out_shadow
);

   localparam int unsigned PH_W  = $clog2(ISSUE_CYC);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned OCC_W = $clog2(DEPTH + 1);

   typedef enum logic {IDLE, ISSUE} state_t;

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic [31:0]     tmin;
      logic [31:0]     tmax;
      logic            miss;
      logic            shadow;
   } ent_t;

   state_t           state, state_nx;
   logic [PH_W-1:0]  ph, ph_nx;
   logic             last_ph;
   logic             run;
   logic [OCC_W-1:0] occ;
   logic             accept;
   logic             pop;
   logic [ID_W-1:0]  id_q;

   logic             tag_v  [RES_LAT];
   logic [ID_W-1:0]  tag_id [RES_LAT];
   logic             tag_sh [RES_LAT];

   ent_t             mem [DEPTH];
   logic [PTR_W:0]   wr_ptr, rd_ptr;
   logic             empty;
   logic             wr_en;
   ent_t             head;

   assign last_ph  = (ph == PH_W'(ISSUE_CYC - 1));
   // run keeps in_ready low while reset is asserted and releases it one edge later
   assign in_ready = run && ((state == IDLE) || last_ph) && (occ < OCC_W'(DEPTH));
   assign accept   = in_valid && in_ready;
   assign empty    = (wr_ptr == rd_ptr);
   assign out_valid = !empty;
   assign pop      = out_valid && out_ready;
   assign wr_en    = tag_v[RES_LAT-1];

   // State register and issue phase counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         ph    <= '0;
      end else begin
         state <= state_nx;
         ph    <= ph_nx;
      end
   end

   // Next state: a ray accepted at the last phase restarts ISSUE back-to-back
   always_comb begin
      state_nx = state;
      ph_nx    = ph;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nx = ISSUE;
               ph_nx    = '0;
            end
         end
         ISSUE: begin
            if (!last_ph) begin
               ph_nx = ph + PH_W'(1);
            end else if (accept) begin
               ph_nx = '0;
            end else begin
               state_nx = IDLE;
               ph_nx    = '0;
            end
         end
         default: begin
            state_nx = IDLE;
            ph_nx    = '0;
         end
      endcase
   end

   // Output decode: one-hot axis strobes during the first three issue phases
   always_comb begin
      pl_v0 = 1'b0;
      pl_v1 = 1'b0;
      pl_v2 = 1'b0;
      if (state == ISSUE) begin
         pl_v0 = (ph == PH_W'(0));
         pl_v1 = (ph == PH_W'(1));
         pl_v2 = (ph == PH_W'(2));
      end
   end

   // Admission enable and accepted-ray latch held stable for the pipeline
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run       <= 1'b0;
         pl_ray    <= '0;
         pl_shadow <= 1'b0;
         id_q      <= '0;
      end else begin
         run <= 1'b1;
         if (accept) begin
            pl_ray    <= in_ray;
            pl_shadow <= in_shadow;
            id_q      <= in_id;
         end
      end
   end

   // Credit counter: rays in flight plus FIFO occupancy
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         occ <= '0;
      end else begin
         case ({accept, pop})
            2'b10:   occ <= occ + OCC_W'(1);
            2'b01:   occ <= occ - OCC_W'(1);
            default: occ <= occ;
         endcase
      end
   end

   // Tag pipe: the last stage lines up with the pipeline result cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < RES_LAT; i++) begin
            tag_v[i]  <= 1'b0;
            tag_id[i] <= '0;
            tag_sh[i] <= 1'b0;
         end
      end else begin
         tag_v[0]  <= pl_v0;
         tag_id[0] <= id_q;
         tag_sh[0] <= pl_shadow;
         for (int unsigned i = 1; i < RES_LAT; i++) begin
            tag_v[i]  <= tag_v[i-1];
            tag_id[i] <= tag_id[i-1];
            tag_sh[i] <= tag_sh[i-1];
         end
      end
   end

   // Result FIFO storage; credits guarantee a free slot on every write
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr[PTR_W-1:0]] <= '{id: tag_id[RES_LAT-1], tmin: pl_tmin, tmax: pl_tmax,
                                     miss: pl_miss, shadow: tag_sh[RES_LAT-1]};
      end
   end

   // FIFO pointers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
         if (pop)   rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
   end

   // Show-ahead head; outputs read as zero while the FIFO is empty
   always_comb begin
      head = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];
   end

   assign out_id     = head.id;
   assign out_tmin   = head.tmin;
   assign out_tmax   = head.tmax;
   assign out_miss   = head.miss;
   assign out_shadow = head.shadow;

endmodule

// File: tb/tb_scene_int_seq.sv
// Directed bench for scene_int_seq with a fixed-latency pipeline model and
// an expected-result queue filled at each accept and consumed at each pop.
module tb_scene_int_seq;

   localparam int unsigned ISSUE_CYC = 4;
   localparam int unsigned RES_LAT   = 40;
   localparam int unsigned DEPTH     = 4;
   localparam int unsigned ID_W      = 8;
   localparam int unsigned RAY_W     = 192;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [RAY_W-1:0] in_ray;
   logic [ID_W-1:0]  in_id;
   logic             in_shadow;
   logic [RAY_W-1:0] pl_ray;
   logic             pl_v0, pl_v1, pl_v2;
   logic             pl_shadow;
   logic [31:0]      pl_tmin, pl_tmax;
   logic             pl_miss;
   logic             out_valid;
   logic             out_ready;
   logic [ID_W-1:0]  out_id;
   logic [31:0]      out_tmin, out_tmax;
   logic             out_miss, out_shadow;

   scene_int_seq #(
      .ISSUE_CYC(ISSUE_CYC),
      .RES_LAT  (RES_LAT),
      .DEPTH    (DEPTH),
      .ID_W     (ID_W),
      .RAY_W    (RAY_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ray    (in_ray),
      .in_id     (in_id),
      .in_shadow (in_shadow),
      .pl_ray    (pl_ray),
      .pl_v0     (pl_v0),
      .pl_v1     (pl_v1),
      .pl_v2     (pl_v2),
      .pl_shadow (pl_shadow),
      .pl_tmin   (pl_tmin),
      .pl_tmax   (pl_tmax),
      .pl_miss   (pl_miss),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_id    (out_id),
      .out_tmin  (out_tmin),
      .out_tmax  (out_tmax),
      .out_miss  (out_miss),
      .out_shadow(out_shadow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Pipeline model: result of the v0 cycle appears RES_LAT cycles later.
   // The ray encodes its own result: [31:0] tmin, [63:32] tmax, [64] miss.
   logic        m_v [RES_LAT];
   logic [64:0] m_d [RES_LAT];
   always @(posedge clk) begin
      m_v[0] <= pl_v0;
      m_d[0] <= pl_ray[64:0];
      for (int i = 1; i < RES_LAT; i++) begin
         m_v[i] <= m_v[i-1];
         m_d[i] <= m_d[i-1];
      end
   end
   assign pl_tmin = m_v[RES_LAT-1] ? m_d[RES_LAT-1][31:0]  : 32'hDEAD_BEEF;
   assign pl_tmax = m_v[RES_LAT-1] ? m_d[RES_LAT-1][63:32] : 32'hDEAD_BEEF;
   assign pl_miss = m_v[RES_LAT-1] ? m_d[RES_LAT-1][64]    : 1'b1;

   typedef struct {
      logic [ID_W-1:0] id;
      logic [31:0]     tmin;
      logic [31:0]     tmax;
      logic            miss;
      logic            shadow;
   } exp_t;

   exp_t        q[$];
   int unsigned pop_cyc[$];
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [RAY_W-1:0] mk_ray(input logic [31:0] tmin, input logic [31:0] tmax,
                                                input logic miss);
      logic [RAY_W-1:0] r;
      r         = '0;
      r[31:0]   = tmin;
      r[63:32]  = tmax;
      r[64]     = miss;
      r[127:96] = 32'h1234_5678;
      return r;
   endfunction

   // Called at a negedge: book-keeps the coming edge's handshakes, then advances.
   task automatic step();
      exp_t e;
      if (in_valid && in_ready) begin
         e.id     = in_id;
         e.tmin   = in_ray[31:0];
         e.tmax   = in_ray[63:32];
         e.miss   = in_ray[64];
         e.shadow = in_shadow;
         q.push_back(e);
         check("credit_bound", 64'(q.size() <= int'(DEPTH)), 64'd1);
      end
      if (out_valid && out_ready) begin
         check("out_expected", 64'(q.size() != 0), 64'd1);
         if (q.size() != 0) begin
            check("out_id",     64'(out_id),     64'(q[0].id));
            check("out_tmin",   64'(out_tmin),   64'(q[0].tmin));
            check("out_tmax",   64'(out_tmax),   64'(q[0].tmax));
            check("out_miss",   64'(out_miss),   64'(q[0].miss));
            check("out_shadow", 64'(out_shadow), 64'(q[0].shadow));
            void'(q.pop_front());
         end
         pop_cyc.push_back(cyc);
      end
      @(negedge clk);
   endtask

   task automatic send(input logic [ID_W-1:0] id, input logic [RAY_W-1:0] ray, input logic sh,
                       output int unsigned acc);
      bit ok;
      ok        = 1'b0;
      acc       = 0;
      in_valid  = 1'b1;
      in_id     = id;
      in_ray    = ray;
      in_shadow = sh;
      for (int i = 0; i < 300 && !ok; i++) begin
         if (in_ready) begin
            acc = cyc;
            ok  = 1'b1;
         end
         step();
      end
      check("send_timeout", 64'(ok), 64'd1);
      in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int unsigned c);
      bit ok;
      ok = 1'b0;
      c  = 0;
      for (int i = 0; i < 300 && !ok; i++) begin
         if (out_valid) begin
            ok = 1'b1;
            c  = cyc;
         end else begin
            step();
         end
      end
      check("valid_timeout", 64'(ok), 64'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 400 && q.size() != 0; i++) step();
      check("drain_empty", 64'(q.size()), 64'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
      check({tag, "_strobes"},  64'({pl_v0, pl_v1, pl_v2}), 64'd0);
      check({tag, "_pl_ray"},   64'(pl_ray[63:0]), 64'd0);
      check({tag, "_pl_ray_hi"}, 64'(pl_ray[127:64]), 64'd0);
      check({tag, "_pl_shadow"}, 64'(pl_shadow), 64'd0);
      check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
      check({tag, "_out_id"},    64'(out_id), 64'd0);
      check({tag, "_out_tmin"},  64'(out_tmin), 64'd0);
      check({tag, "_out_tmax"},  64'(out_tmax), 64'd0);
      check({tag, "_out_flags"}, 64'({out_miss, out_shadow}), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned a, c, acc[5];
      logic [RAY_W-1:0] ray;
      logic [2:0] exp_s;
      bit seen;

      rst       = 1'b0;
      in_valid  = 1'b0;
      in_id     = '0;
      in_ray    = '0;
      in_shadow = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst0");
      rst = 1'b1;
      step();
      step();
      check("ready_after_rst", 64'(in_ready), 64'd1);

      // Single ray: strobe timing and RES_LAT+2 latency
      out_ready = 1'b1;
      ray = mk_ray(32'h3F80_0000, 32'h4000_0000, 1'b0);
      send(8'h11, ray, 1'b0, a);
      check("t1_phase", 64'(cyc - a), 64'd1);
      for (int k = 1; k <= 5; k++) begin
         exp_s = (k == 1) ? 3'b100 : (k == 2) ? 3'b010 : (k == 3) ? 3'b001 : 3'b000;
         check("t1_strobes", 64'({pl_v0, pl_v1, pl_v2}), 64'(exp_s));
         check("t1_pl_ray", 64'(pl_ray[63:0]), 64'(ray[63:0]));
         check("t1_pl_shadow", 64'(pl_shadow), 64'd0);
         step();
      end
      wait_valid(c);
      check("t1_latency", 64'(c - a), 64'(RES_LAT + 2));
      check("t1_out_id", 64'(out_id), 64'h11);
      drain();

      // Four back-to-back rays with out_ready held high
      pop_cyc.delete();
      for (int i = 0; i < 4; i++)
         send(ID_W'(i + 1), mk_ray(32'h1000 + 32'(i), 32'h2000 + 32'(i), 1'b0), 1'b0, acc[i]);
      for (int i = 1; i < 4; i++) check("t2_issue_gap", 64'(acc[i] - acc[i-1]), 64'(ISSUE_CYC));
      drain();
      check("t2_pop_count", 64'(pop_cyc.size()), 64'd4);
      if (pop_cyc.size() == 4) begin
         check("t2_first_lat", 64'(pop_cyc[0] - acc[0]), 64'(RES_LAT + 2));
         for (int i = 1; i < 4; i++)
            check("t2_out_gap", 64'(pop_cyc[i] - pop_cyc[i-1]), 64'(ISSUE_CYC));
      end

      // Back-pressure: credits exhausted, then released by a single pop
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         send(ID_W'(8'h21 + i), mk_ray(32'h3000 + 32'(i), 32'h4000 + 32'(i), 1'b0), 1'b0, acc[i]);
      in_valid  = 1'b1;
      in_id     = 8'h25;
      in_ray    = mk_ray(32'h3004, 32'h4004, 1'b0);
      in_shadow = 1'b0;
      repeat (50) step();
      check("t3_ready_low", 64'(in_ready), 64'd0);
      check("t3_out_valid", 64'(out_valid), 64'd1);
      check("t3_head_id", 64'(out_id), 64'h21);
      check("t3_q_size", 64'(q.size()), 64'd4);
      out_ready = 1'b1;
      check("t3_no_comb_credit", 64'(in_ready), 64'd0);
      step();
      out_ready = 1'b0;
      check("t3_credit_release", 64'(in_ready), 64'd1);
      step();
      in_valid = 1'b0;
      check("t3_accept5", 64'(q.size()), 64'd4);

      // Accept and pop on the same edge; credit count stays put
      repeat (4) step();
      in_valid  = 1'b1;
      in_id     = 8'h26;
      in_ray    = mk_ray(32'h3005, 32'h4005, 1'b0);
      out_ready = 1'b1;
      check("t4_full_credit", 64'(in_ready), 64'd0);
      step();
      check("t4_release", 64'(in_ready), 64'd1);
      step();
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check("t4_same_edge_q", 64'(q.size()), 64'd3);
      repeat (4) step();
      send(8'h27, mk_ray(32'h3006, 32'h4006, 1'b0), 1'b0, a);
      in_valid  = 1'b1;
      in_id     = 8'h28;
      in_ray    = mk_ray(32'h3007, 32'h4007, 1'b0);
      repeat (50) step();
      check("t4_occ_full", 64'(in_ready), 64'd0);
      check("t4_fifo_full_head", 64'(out_id), 64'h24);
      check("t4_q_full", 64'(q.size()), 64'(DEPTH));
      out_ready = 1'b1;
      for (int i = 0; i < 400 && in_valid; i++) begin
         if (in_ready) begin
            step();
            in_valid = 1'b0;
         end else begin
            step();
         end
      end
      check("t4_accept8", 64'(in_valid), 64'd0);
      drain();

      // Miss and shadow flags with the maximum ID
      send(8'hFF, mk_ray(32'h7F80_0000, 32'h7F80_0000, 1'b1), 1'b1, a);
      wait_valid(c);
      check("t5_latency", 64'(c - a), 64'(RES_LAT + 2));
      check("t5_id", 64'(out_id), 64'hFF);
      check("t5_miss", 64'(out_miss), 64'd1);
      check("t5_shadow", 64'(out_shadow), 64'd1);
      drain();

      // Reset with one result in the FIFO and two rays in flight
      out_ready = 1'b0;
      send(8'hA1, mk_ray(32'h5001, 32'h6001, 1'b0), 1'b0, a);
      send(8'hA2, mk_ray(32'h5002, 32'h6002, 1'b0), 1'b1, c);
      send(8'hA3, mk_ray(32'h5003, 32'h6003, 1'b1), 1'b0, c);
      wait_valid(c);
      check("t6_head_before_rst", 64'(out_id), 64'hA1);
      rst = 1'b0;
      #1;
      check_reset_outputs("rst1");
      @(negedge clk);
      check_reset_outputs("rst1_hold");
      rst = 1'b1;
      q.delete();
      seen = 1'b0;
      for (int i = 0; i < 2 * RES_LAT; i++) begin
         seen |= out_valid;
         step();
      end
      check("t6_no_stale_out", 64'(seen), 64'd0);
      out_ready = 1'b1;
      send(8'h55, mk_ray(32'h3F00_0000, 32'h4100_0000, 1'b0), 1'b0, a);
      wait_valid(c);
      check("t6_latency", 64'(c - a), 64'(RES_LAT + 2));
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
